// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory request at a time, checks size alignment
// and RAM range, drives the byte-laned RAM port and returns a formatted load
// result or store completion (with a fault flag) on a valid/ready channel.
module load_store_unit #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h2000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_fault,
  output logic [1:0]            mem_size,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic                    req_ready_r;
  logic                    rsp_valid_r;
  logic                    access_wr_r;
  logic                    wr_r;
  logic                    signed_r;
  logic [1:0]              mem_size_r;
  logic [ADDR_WIDTH-1:0]   mem_address_r;
  logic [31:0]             mem_write_data_r;
  logic [31:0]             rsp_rdata_r;
  logic                    rsp_fault_r;
  logic                    accept_s;
  logic                    fault_s;

  // Misalignment, illegal size, or address outside the RAM window.
  function automatic logic addr_fault(input logic [1:0] size, input logic [31:0] addr);
    logic bad;
    bad = (addr[31:ADDR_WIDTH] != BASE_ADDR[31:ADDR_WIDTH]);
    case (size)
      2'b00:   addr_fault = bad;
      2'b01:   addr_fault = bad | addr[0];
      2'b10:   addr_fault = bad | (addr[1:0] != 2'b00);
      default: addr_fault = 1'b1;
    endcase
  endfunction

  // Replicate right-justified store data onto every lane it may occupy.
  function automatic logic [31:0] lane_place(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   lane_place = {4{wdata[7:0]}};
      2'b01:   lane_place = {2{wdata[15:0]}};
      2'b10:   lane_place = wdata;
      default: lane_place = wdata;
    endcase
  endfunction

  // Zero/sign-extend right-justified RAM read data to 32 bits.
  function automatic logic [31:0] load_format(input logic [1:0] size, input logic sgn,
                                              input logic [31:0] d);
    case (size)
      2'b00:   load_format = sgn ? {{24{d[7]}}, d[7:0]}   : {24'd0, d[7:0]};
      2'b01:   load_format = sgn ? {{16{d[15]}}, d[15:0]} : {16'd0, d[15:0]};
      2'b10:   load_format = d;
      default: load_format = 32'd0;
    endcase
  endfunction

  assign accept_s = req_valid & req_ready_r;
  assign fault_s  = addr_fault(req_size, req_addr);

  // Next-state decode of the access sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (fault_s) begin
            state_s = RESP;
          end else begin
            state_s = ACCESS;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (wr_r) begin
          state_s = RESP;
        end else begin
          state_s = CAPTURE;
        end
      end
      CAPTURE: state_s = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register plus handshake flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      access_wr_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      req_ready_r <= (state_s == IDLE);
      rsp_valid_r <= (state_s == RESP);
      // ACCESS is only ever entered straight from an accept in IDLE.
      access_wr_r <= (state_s == ACCESS) & req_write;
    end
  end

  // Latch the accepted request; RAM-side fields hold until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_r             <= 1'b0;
      signed_r         <= 1'b0;
      mem_size_r       <= 2'b00;
      mem_address_r    <= '0;
      mem_write_data_r <= 32'd0;
    end else if (accept_s) begin
      wr_r             <= req_write;
      signed_r         <= req_signed;
      mem_size_r       <= req_size;
      mem_address_r    <= req_addr[ADDR_WIDTH-1:0];
      mem_write_data_r <= lane_place(req_size, req_wdata);
    end else begin
      wr_r             <= wr_r;
      signed_r         <= signed_r;
      mem_size_r       <= mem_size_r;
      mem_address_r    <= mem_address_r;
      mem_write_data_r <= mem_write_data_r;
    end
  end

  // Response payload: cleared/faulted at accept, load data captured after the RAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata_r <= 32'd0;
      rsp_fault_r <= 1'b0;
    end else if (accept_s) begin
      rsp_rdata_r <= 32'd0;
      rsp_fault_r <= fault_s;
    end else if (state_r == CAPTURE) begin
      rsp_rdata_r <= load_format(mem_size_r, signed_r, mem_read_data);
      rsp_fault_r <= rsp_fault_r;
    end else begin
      rsp_rdata_r <= rsp_rdata_r;
      rsp_fault_r <= rsp_fault_r;
    end
  end

  assign req_ready        = req_ready_r;
  assign rsp_valid        = rsp_valid_r;
  assign rsp_rdata        = rsp_rdata_r;
  assign rsp_fault        = rsp_fault_r;
  assign mem_size         = mem_size_r;
  assign mem_address      = mem_address_r;
  assign mem_write_data   = mem_write_data_r;
  // Gated by rst so a store caught in ACCESS by a reset never reaches the RAM.
  assign mem_write_enable = access_wr_r & ~rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: byte-addressed RAM model on the memory port,
// reference memory plus queue of expected responses, and a monitor that checks
// each response, its latency, and the store write pulses.
module tb_load_store_unit;

  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [1:0]  mem_size;
  logic        mem_write_enable;
  logic [9:0]  mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  load_store_unit #(.ADDR_WIDTH(10), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault),
    .mem_size(mem_size), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          nwr;
    logic [31:0] wd;
    logic [1:0]  size;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  ref_mem [0:1023];
  logic [7:0]  ram [0:1023];
  bit          ram_ready = 1'b0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37 + 5) % 256);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // RAM: byte-addressed, writes the data found on the address's own lanes,
  // registered read returns bytes starting at the address, right-justified.
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_byte(i);
      ram_ready <= 1'b1;
    end else if (mem_write_enable) begin
      case (mem_size)
        2'b00: ram[mem_address] <= mem_write_data[8*mem_address[1:0] +: 8];
        2'b01: begin
          ram[mem_address]         <= mem_write_data[8*mem_address[1:0] +: 8];
          ram[mem_address + 10'd1] <= mem_write_data[8*mem_address[1:0] + 8 +: 8];
        end
        default: begin
          ram[mem_address]         <= mem_write_data[7:0];
          ram[mem_address + 10'd1] <= mem_write_data[15:8];
          ram[mem_address + 10'd2] <= mem_write_data[23:16];
          ram[mem_address + 10'd3] <= mem_write_data[31:24];
        end
      endcase
    end
    mem_read_data <= {ram[mem_address + 10'd3], ram[mem_address + 10'd2],
                      ram[mem_address + 10'd1], ram[mem_address]};
  end

  // Reference model: decides the outcome of a request from address arithmetic
  // and updates the reference memory for accepted stores.
  function automatic exp_t predict(input bit wr, input logic [1:0] sz, input bit sg,
                                   input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int   nb;
    int   off;
    logic [31:0] v;
    nb = 1 << sz;
    e.fault = (sz == 2'd3) || (a < BASE) || (a >= BASE + 32'd1024) || ((a % nb) != 0);
    e.rdata = 32'd0;
    e.nwr   = 0;
    e.size  = sz;
    e.acc   = 0;
    for (int i = 0; i < 4; i++) e.wd[8*i +: 8] = wd[8*(i % nb) +: 8];
    if (e.fault) begin
      e.lat = 1;
    end else begin
      off = int'(a - BASE);
      if (wr) begin
        e.lat = 2;
        e.nwr = 1;
        for (int i = 0; i < nb; i++) ref_mem[off + i] = wd[8*i +: 8];
      end else begin
        e.lat = 3;
        v = 32'd0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[off + i];
        if (sg && nb < 4 && v[8*nb - 1]) begin
          for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        e.rdata = v;
      end
    end
    return e;
  endfunction

  // Issue one request and complete its response handshake with the given stall.
  task automatic issue(input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd, input int stall);
    exp_t e;
    int   n;
    int   st;
    bit   done;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: req_ready stayed 0, expected 1");
      return;
    end
    e = predict(wr, sz, sg, a, wd);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    rsp_ready = (stall == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    st = stall;
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      if (rsp_valid) begin
        if (st > 0) begin
          rsp_ready = 1'b0;
          st--;
        end else begin
          rsp_ready = 1'b1;
        end
      end
      if (rsp_valid && rsp_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_timeout: no response handshake for addr %h", a);
    end else begin
      check("ready_after_rsp", {31'd0, req_ready}, 32'd1);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_rsp_fault"}, {31'd0, rsp_fault}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_write_enable}, 32'd0);
    check({tag, "_mem_size"}, {30'd0, mem_size}, 32'd0);
    check({tag, "_mem_address"}, {22'd0, mem_address}, 32'd0);
    check({tag, "_mem_wdata"}, mem_write_data, 32'd0);
  endtask

  // Monitor: compares every presented response and write pulse with the queue head.
  initial begin
    int  we_cnt;
    bit  prev_valid;
    we_cnt = 0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        we_cnt = 0;
        prev_valid = 1'b0;
      end else begin
        if (mem_write_enable) begin
          we_cnt++;
          if (exp_q.size() > 0) begin
            check("mem_write_data", mem_write_data, exp_q[0].wd);
            check("mem_size", {30'd0, mem_size}, {30'd0, exp_q[0].size});
          end
        end
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding");
          end else begin
            if (!prev_valid) check("latency", 32'(cyc - exp_q[0].acc + 1), 32'(exp_q[0].lat));
            check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
            check("rsp_fault", {31'd0, rsp_fault}, {31'd0, exp_q[0].fault});
            check("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
            if (rsp_ready) begin
              check("write_count", 32'(we_cnt), 32'(exp_q[0].nwr));
              we_cnt = 0;
              void'(exp_q.pop_front());
            end
          end
        end
        prev_valid = rsp_valid;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          off;
    int          r;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    rst = 1'b0;

    // Word store/load.
    issue(1'b1, 2'b10, 1'b0, 32'h2000_0010, 32'hDEAD_BEEF, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h2000_0010, 32'h0, 0);
    // Byte lanes and sign extension.
    issue(1'b1, 2'b00, 1'b0, 32'h2000_0021, 32'h0000_0080, 0);
    issue(1'b0, 2'b00, 1'b1, 32'h2000_0021, 32'h0, 0);
    issue(1'b0, 2'b00, 1'b0, 32'h2000_0021, 32'h0, 0);
    // Halfword.
    issue(1'b1, 2'b01, 1'b0, 32'h2000_0042, 32'h1234_9ABC, 0);
    issue(1'b0, 2'b01, 1'b1, 32'h2000_0042, 32'h0, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h2000_0040, 32'h0, 0);
    // Faults (as stores, so a stray write would be seen).
    issue(1'b1, 2'b01, 1'b0, 32'h2000_0001, 32'hFFFF_FFFF, 0);
    issue(1'b1, 2'b10, 1'b0, 32'h2000_0002, 32'hFFFF_FFFF, 0);
    issue(1'b1, 2'b11, 1'b0, 32'h2000_0000, 32'hFFFF_FFFF, 0);
    issue(1'b1, 2'b10, 1'b0, 32'h2000_0400, 32'hFFFF_FFFF, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h2000_0040, 32'h0, 0);
    // Backpressure for 5 cycles on a load response.
    issue(1'b0, 2'b10, 1'b0, 32'h2000_0010, 32'h0, 5);

    // Reset during ACCESS of a store must not write.
    issue(1'b1, 2'b10, 1'b0, 32'h2000_0000, 32'h0000_0000, 0);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h2000_0000; req_wdata = 32'h5555_5555;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_reset_values("mid_rst");
    issue(1'b0, 2'b10, 1'b0, 32'h2000_0000, 32'h0, 0);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      r  = $urandom_range(0, 9);
      sz = (r == 9) ? 2'b11 : 2'(r % 3);
      off = $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0) off = off & ~((1 << sz) - 1);
      a = BASE + 32'(off);
      r = $urandom_range(0, 15);
      if (r == 0) a = $urandom();
      else if (r == 1) a = BASE + 32'h400 + 32'(off);
      else if (r == 2) a = BASE - 32'd4;
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom(),
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
